// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key_debounce input conditioner.
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    LONG     = 2'd2
  } key_state_t;

  // 20 ms and 1 s at a 100 MHz system clock
  localparam int KEY_DEBOUNCE_DEFAULT = 2_000_000;
  localparam int KEY_LONG_DEFAULT     = 100_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release FSM.
// Long-press detection (hold counter, LONG state) is built only with KEY_LONG_PRESS_EN.
//
// state    | meaning
// RELEASED | accepted level 0, hold counter kept clear
// PRESSED  | accepted level 1, hold counter running toward the long threshold
// LONG     | accepted level 1, long pulse already issued, hold counter frozen
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = KEY_DEBOUNCE_DEFAULT,
  parameter int LONG_CNT     = KEY_LONG_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = $clog2(DEBOUNCE_CNT) + 1;

  logic          r_s1;
  logic          r_s2;
  logic [DW-1:0] r_dcnt;
  key_state_t    r_state;
  key_state_t    w_state_nxt;
  logic          r_press;
  logic          r_release;
  logic          r_long;
  logic          w_press_nxt;
  logic          w_release_nxt;
  logic          w_long_nxt;
  logic          w_level;
  logic          w_accept;
  logic          w_hold_done;

  assign w_level  = (r_state != RELEASED);
  assign w_accept = (r_s2 != w_level) && (r_dcnt == DW'(DEBOUNCE_CNT - 1));

  // Any single cycle of agreement with the accepted level restarts the count
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_dcnt <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if ((r_s2 == w_level) || w_accept) r_dcnt <= '0;
      else                               r_dcnt <= r_dcnt + 1'b1;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CNT) + 1;

  logic [HW-1:0] r_hcnt;

  assign w_hold_done = (r_hcnt == HW'(LONG_CNT - 1));

  // Stops at the threshold; LONG holds it frozen until release
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == RELEASED)) begin
      r_hcnt <= '0;
    end else if ((r_state == PRESSED) && !w_hold_done) begin
      r_hcnt <= r_hcnt + 1'b1;
    end
  end
`else
  logic w_unused_long;

  assign w_hold_done   = 1'b0;
  assign w_unused_long = (LONG_CNT > DEBOUNCE_CNT);
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_accept) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        // Release takes precedence over a coincident long threshold
        if (w_accept) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
        end else if (w_hold_done) begin
          w_state_nxt = LONG;
          w_long_nxt  = 1'b1;
        end
      end
`ifdef KEY_LONG_PRESS_EN
      LONG: begin
        if (w_accept) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
        end
      end
`endif
      default: w_state_nxt = RELEASED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RELEASED;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
    end
  end

  assign o_level   = w_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule

// File: rtl/key_debounce.sv
// N independent push-button conditioners producing clean level and press/release/long pulses.
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int N            = 4,
  parameter int DEBOUNCE_CNT = KEY_DEBOUNCE_DEFAULT,
  parameter int LONG_CNT     = KEY_LONG_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_long
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .LONG_CNT     (LONG_CNT)
    ) u_ch (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_btn     (btn_in[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_long    (btn_long[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (N=2, DEBOUNCE_CNT=4, LONG_CNT=16).
// Long-press expectations follow KEY_LONG_PRESS_EN as defined for the build.
module tb_key_debounce;

  localparam int N    = 2;
  localparam int DB   = 4;
  localparam int LG   = 16;
  localparam int MAXR = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;

  always #5 clk = ~clk;

  key_debounce #(
    .N            (N),
    .DEBOUNCE_CNT (DB),
    .LONG_CNT     (LG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  // Row i: inputs applied before edge i, outputs expected just after edge i
  typedef struct {
    int           sid;
    int           row;
    logic         rst;
    logic [N-1:0] in;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] lng;
  } vec_t;

  vec_t sc [MAXR];
  vec_t exp_q [$];
  vec_t e;
  int   nrows = 0;
  int   sid   = 0;
  int   checks   = 0;
  int   failures = 0;

  task automatic new_sc(input int n);
    nrows = n;
    sid++;
    for (int i = 0; i < MAXR; i++) begin
      sc[i].sid = sid;
      sc[i].row = i;
      sc[i].rst = (i < 3);
      sc[i].in  = '0;
      sc[i].lvl = '0;
      sc[i].prs = '0;
      sc[i].rel = '0;
      sc[i].lng = '0;
    end
  endtask

  task automatic set_rst(input int a, input int b);
    for (int i = a; i <= b && i < MAXR; i++) sc[i].rst = 1'b1;
  endtask

  task automatic set_in(input int ch, input int a, input int b);
    for (int i = a; i <= b && i < MAXR; i++) sc[i].in[ch] = 1'b1;
  endtask

  task automatic set_lvl(input int ch, input int a, input int b);
    for (int i = a; i <= b && i < MAXR; i++) sc[i].lvl[ch] = 1'b1;
  endtask

  task automatic set_prs(input int ch, input int r);
    sc[r].prs[ch] = 1'b1;
  endtask

  task automatic set_rel(input int ch, input int r);
    sc[r].rel[ch] = 1'b1;
  endtask

  task automatic set_lng(input int ch, input int r);
    sc[r].lng[ch] = 1'b1;
  endtask

  task automatic run_sc();
    for (int i = 0; i < nrows; i++) begin
      @(negedge clk);
      rst    = sc[i].rst;
      btn_in = sc[i].in;
      exp_q.push_back(sc[i]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({btn_level, btn_press, btn_release, btn_long} !== {e.lvl, e.prs, e.rel, e.lng}) begin
          failures++;
          $display("FAIL s%0d row%0d: got lvl=%b prs=%b rel=%b lng=%b, want lvl=%b prs=%b rel=%b lng=%b",
                   e.sid, e.row, btn_level, btn_press, btn_release, btn_long,
                   e.lvl, e.prs, e.rel, e.lng);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: both held through reset, accepted 5 cycles after reset release
    new_sc(20);
    set_in(0, 0, 19);
    set_in(1, 0, 19);
    set_prs(0, 8);
    set_prs(1, 8);
    set_lvl(0, 8, 19);
    set_lvl(1, 8, 19);
    run_sc();

    // 2: clean press at 10, release at 30
    new_sc(45);
    set_in(0, 10, 29);
    set_prs(0, 15);
    set_lvl(0, 15, 34);
    set_rel(0, 35);
`ifdef KEY_LONG_PRESS_EN
    set_lng(0, 31);
`endif
    run_sc();

    // 3: bounce 1,0,1,0,1 then hold; timed from the last rising sample
    new_sc(33);
    set_in(0, 10, 10);
    set_in(0, 12, 12);
    set_in(0, 14, 32);
    set_prs(0, 19);
    set_lvl(0, 19, 32);
    run_sc();

    // 4: ch1 3-cycle glitch ignored, ch0 exactly DEBOUNCE_CNT wide accepted
    new_sc(25);
    set_in(1, 10, 12);
    set_in(0, 10, 13);
    set_prs(0, 15);
    set_lvl(0, 15, 18);
    set_rel(0, 19);
    run_sc();

    // 5: long hold, single long pulse 16 cycles after press
    new_sc(56);
    set_in(0, 5, 45);
    set_prs(0, 10);
    set_lvl(0, 10, 50);
    set_rel(0, 51);
`ifdef KEY_LONG_PRESS_EN
    set_lng(0, 26);
`endif
    run_sc();

    // 6: staggered presses, reset while held, fresh re-press afterwards
    new_sc(26);
    set_in(0, 5, 25);
    set_in(1, 6, 25);
    set_rst(14, 15);
    set_prs(0, 10);
    set_prs(1, 11);
    set_lvl(0, 10, 13);
    set_lvl(1, 11, 13);
    set_prs(0, 21);
    set_prs(1, 21);
    set_lvl(0, 21, 25);
    set_lvl(1, 21, 25);
    run_sc();

    // 7: release acceptance on the long-threshold cycle: release only
    new_sc(35);
    set_in(0, 5, 20);
    set_prs(0, 10);
    set_lvl(0, 10, 25);
    set_rel(0, 26);
    run_sc();

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
